// File: rtl/restoring_divider_16bit.sv
// restoring_divider_16bit
//   Sequential unsigned divider built on restoring shift-and-subtract.
//   It produces one quotient bit per clock, so WIDTH iterations make one result.
//   A start/done handshake controls it. Results stay stable until the next
//   operation completes.
//
// Ports
//   in_clk           clock, rising edge
//   in_rst_n         asynchronous active-low reset
//   in_start         operation request, accepted when not busy (IDLE or DONE)
//   in_dividend      unsigned dividend, sampled with an accepted start
//   in_divisor       unsigned divisor, sampled with an accepted start
//   out_busy         high while iterations are running
//   out_done         one-cycle pulse, results valid from this cycle
//   out_quotient     registered quotient
//   out_remainder    registered remainder
//   out_div_by_zero  set when the last completed operation had divisor 0
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for in_start
// RUN   | one shift-and-subtract iteration per clock, WIDTH iterations
// DONE  | single cycle with out_done=1; a new start is accepted here too

module restoring_divider_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CW-1:0]    iter_cnt;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // The working remainder always stays below the divisor. Its top bit is
  // therefore zero before the shift, and shifting at WIDTH+1 bits loses nothing.
  // A set MSB in the trial means the subtraction borrowed. In that case the
  // shifted remainder is restored.
  always_comb begin
    rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    if (!trial[WIDTH]) begin
      rem_next = trial;
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift;
      quo_next = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state           <= IDLE;
      rem_q           <= '0;
      quo_q           <= '0;
      divisor_q       <= '0;
      iter_cnt        <= '0;
      out_busy        <= 1'b0;
      out_done        <= 1'b0;
      out_quotient    <= '0;
      out_remainder   <= '0;
      out_div_by_zero <= 1'b0;
    end else begin
      out_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (in_start) begin
            divisor_q <= in_divisor;
            if (in_divisor != '0) begin
              rem_q    <= '0;
              quo_q    <= in_dividend;
              iter_cnt <= '0;
              out_busy <= 1'b1;
              state    <= RUN;
            end else begin
              // Divide by zero completes at once. The dividend is returned as
              // the remainder, with an all-ones quotient.
              out_quotient    <= '1;
              out_remainder   <= in_dividend;
              out_div_by_zero <= 1'b1;
              out_done        <= 1'b1;
              state           <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem_q    <= rem_next;
          quo_q    <= quo_next;
          iter_cnt <= iter_cnt + 1'b1;
          if (iter_cnt == LAST_ITER) begin
            out_quotient    <= quo_next;
            out_remainder   <= rem_next[WIDTH-1:0];
            out_div_by_zero <= 1'b0;
            out_done        <= 1'b1;
            out_busy        <= 1'b0;
            state           <= DONE;
          end
        end
        default: begin
          out_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_16bit.sv
module tb_restoring_divider_16bit;

  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic [15:0] in_dividend = '0;
  logic [15:0] in_divisor = '0;
  logic        out_busy;
  logic        out_done;
  logic [15:0] out_quotient;
  logic [15:0] out_remainder;
  logic        out_div_by_zero;

  int checks = 0;
  int errors = 0;

  restoring_divider_16bit #(.WIDTH(16)) dut (
    .in_clk         (in_clk),
    .in_rst_n       (in_rst_n),
    .in_start       (in_start),
    .in_dividend    (in_dividend),
    .in_divisor     (in_divisor),
    .out_busy       (out_busy),
    .out_done       (out_done),
    .out_quotient   (out_quotient),
    .out_remainder  (out_remainder),
    .out_div_by_zero(out_div_by_zero)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model at the level of the handshake. An accepted start yields
  // a/b and a%b with done 16 edges later. Divisor 0 yields its result after
  // the very next edge. A start is ignored while the previous op is busy.
  int          edge_n = 0;
  int          busy_end = 0;
  int          pend_edge = -1;
  logic [15:0] p_q = '0, p_r = '0;
  logic [15:0] m_q = '0, m_r = '0;
  logic        m_z = 1'b0, m_done = 1'b0, m_busy = 1'b0;

  always @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      busy_end  = edge_n;
      pend_edge = -1;
      m_q = '0; m_r = '0; m_z = 1'b0; m_done = 1'b0; m_busy = 1'b0;
    end else begin
      edge_n++;
      m_done = 1'b0;
      if (edge_n == pend_edge) begin
        m_q = p_q; m_r = p_r; m_z = 1'b0; m_done = 1'b1;
        pend_edge = -1;
      end
      if (in_start && !m_busy) begin
        if (in_divisor == 16'd0) begin
          m_q = 16'hFFFF; m_r = in_dividend; m_z = 1'b1; m_done = 1'b1;
        end else begin
          p_q = in_dividend / in_divisor;
          p_r = in_dividend % in_divisor;
          pend_edge = edge_n + 16;
          busy_end  = edge_n + 16;
        end
      end
      m_busy = (edge_n < busy_end);
    end
  end

  always @(negedge in_clk) begin
    chk("busy", {31'd0, out_busy}, {31'd0, m_busy});
    chk("done", {31'd0, out_done}, {31'd0, m_done});
    chk("quotient", {16'd0, out_quotient}, {16'd0, m_q});
    chk("remainder", {16'd0, out_remainder}, {16'd0, m_r});
    chk("div_by_zero", {31'd0, out_div_by_zero}, {31'd0, m_z});
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit b2b,
                        input int inj_at, input logic [15:0] ia, input logic [15:0] ib,
                        output logic [15:0] q, output logic [15:0] r, output logic z,
                        output int busy_cnt);
    bit got;
    if (!b2b) @(negedge in_clk);
    in_start = 1'b1; in_dividend = a; in_divisor = b;
    busy_cnt = 0; got = 1'b0; q = '0; r = '0; z = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge in_clk);
      if (i == inj_at) begin
        in_start = 1'b1; in_dividend = ia; in_divisor = ib;
      end else begin
        in_start = 1'b0;
      end
      if (out_busy) busy_cnt++;
      if (out_done) begin
        got = 1'b1; q = out_quotient; r = out_remainder; z = out_div_by_zero;
        break;
      end
    end
    in_start = 1'b0;
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic op_lit(input string name, input logic [15:0] a, input logic [15:0] b,
                        input bit b2b, input int inj_at,
                        input logic [15:0] eq, input logic [15:0] er, input logic ez,
                        input int ebusy);
    logic [15:0] q, r;
    logic        z;
    int          bc;
    run_op(a, b, b2b, inj_at, 16'd50, 16'd5, q, r, z, bc);
    chk({name, "_q"}, {16'd0, q}, {16'd0, eq});
    chk({name, "_r"}, {16'd0, r}, {16'd0, er});
    chk({name, "_z"}, {31'd0, z}, {31'd0, ez});
    chk({name, "_busy_cycles"}, bc, ebusy);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b, q, r;
    logic        z;
    int          bc, dones;

    repeat (2) @(negedge in_clk);
    chk("rst_busy", {31'd0, out_busy}, 32'd0);
    chk("rst_done", {31'd0, out_done}, 32'd0);
    chk("rst_q", {16'd0, out_quotient}, 32'd0);
    chk("rst_r", {16'd0, out_remainder}, 32'd0);
    chk("rst_z", {31'd0, out_div_by_zero}, 32'd0);
    in_rst_n = 1'b1;
    repeat (2) @(negedge in_clk);

    op_lit("d100_7", 16'd100, 16'd7, 1'b0, -1, 16'd14, 16'd2, 1'b0, 16);
    op_lit("dffff_1", 16'hFFFF, 16'h0001, 1'b0, -1, 16'hFFFF, 16'd0, 1'b0, 16);
    op_lit("d3_10", 16'd3, 16'd10, 1'b0, -1, 16'd0, 16'd3, 1'b0, 16);
    op_lit("dffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, -1, 16'd1, 16'd0, 1'b0, 16);
    op_lit("d5_0", 16'd5, 16'd0, 1'b0, -1, 16'hFFFF, 16'd5, 1'b1, 0);
    op_lit("d9_3", 16'd9, 16'd3, 1'b0, -1, 16'd3, 16'd0, 1'b0, 16);
    // A second start sampled at E0+5 must be ignored.
    op_lit("d1000_3", 16'd1000, 16'd3, 1'b0, 4, 16'd333, 16'd1, 1'b0, 16);
    // Started in the DONE cycle of the previous op.
    op_lit("b2b_77_8", 16'd77, 16'd8, 1'b1, -1, 16'd9, 16'd5, 1'b0, 16);
    op_lit("b2b_div0", 16'd42, 16'd0, 1'b1, -1, 16'hFFFF, 16'd42, 1'b1, 0);
    op_lit("after_div0", 16'd65535, 16'd256, 1'b1, -1, 16'd255, 16'd255, 1'b0, 16);

    // Reset in the middle of RUN abandons the op.
    @(negedge in_clk);
    in_start = 1'b1; in_dividend = 16'd1234; in_divisor = 16'd5;
    @(negedge in_clk);
    in_start = 1'b0;
    repeat (7) @(negedge in_clk);
    #2 in_rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, out_busy}, 32'd0);
    chk("midrst_done", {31'd0, out_done}, 32'd0);
    chk("midrst_q", {16'd0, out_quotient}, 32'd0);
    chk("midrst_r", {16'd0, out_remainder}, 32'd0);
    chk("midrst_z", {31'd0, out_div_by_zero}, 32'd0);
    repeat (3) @(negedge in_clk);
    in_rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge in_clk);
      if (out_done) dones++;
    end
    chk("midrst_no_done", dones, 0);

    for (int n = 0; n < 2500; n++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 99) < 5) b = 16'd0;
      else begin
        case ($urandom_range(0, 2))
          0:       b = 16'($urandom_range(1, 65535));
          1:       b = 16'($urandom_range(1, 15));
          default: b = 16'($urandom_range(1, 255));
        endcase
      end
      run_op(a, b, ($urandom_range(0, 3) == 0), -1, 16'd0, 16'd0, q, r, z, bc);
      if (b == 16'd0) begin
        chk("rnd_q", {16'd0, q}, 32'hFFFF);
        chk("rnd_r", {16'd0, r}, {16'd0, a});
        chk("rnd_z", {31'd0, z}, 32'd1);
      end else begin
        chk("rnd_q", {16'd0, q}, {16'd0, a / b});
        chk("rnd_r", {16'd0, r}, {16'd0, a % b});
        chk("rnd_z", {31'd0, z}, 32'd0);
      end
    end

    repeat (4) @(negedge in_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
